// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control FSM and its counter datapath:
// command codes, FSM mode codes, count ceiling and BCD helper functions.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD      = 3'b000,
        CMD_INC       = 3'b001,
        CMD_DEC       = 3'b010,
        CMD_LOAD_0    = 3'b011,
        CMD_LOAD_9999 = 3'b100,
        CMD_LOAD_EXT  = 3'b101
    } sw_cmd_e;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_UP    = 2'b01,
        MODE_DOWN  = 2'b10,
        MODE_PAUSE = 2'b11
    } sw_mode_e;

    typedef enum logic [2:0] {
        ST_RESET   = 3'b000,
        ST_STOPPED = 3'b001,
        ST_RUN_UP  = 3'b010,
        ST_RUN_DN  = 3'b011,
        ST_PAUSED  = 3'b100,
        ST_PRESET  = 3'b101
    } sw_state_e;

    localparam int SW_MAX_CNT = 9999;

    // Any nibble above 9 is forced to 9 so a preset can never leave the BCD domain.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [13:0] bcd_to_bin(input logic [15:0] b);
        logic [13:0] t;
        t = {10'd0, b[15:12]} * 14'd1000
          + {10'd0, b[11:8]}  * 14'd100
          + {10'd0, b[7:4]}   * 14'd10
          + {10'd0, b[3:0]};
        return t;
    endfunction

    function automatic logic bcd_is_valid(input logic [15:0] b);
        return (b[15:12] <= 4'd9) && (b[11:8] <= 4'd9) &&
               (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 up/down BCD digit. cout_o flags a carry (up, at 9) or borrow
// (down, at 0) in the same cycle it is enabled, feeding the next digit's enable.
module bcd_digit (
    input  logic       CLK,
    input  logic       reset,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic       cout_o
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next digit value: load wins, otherwise wrap-around step when enabled.
    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end
        end else begin
            digit_d = digit_q;
        end
    end

    // Digit register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign cout_o  = en_i && !load_i && (up_i ? (digit_q == 4'd9) : (digit_q == 4'd0));

endmodule

// File: rtl/stopwatch_counter_chk.sv
// Property checker for the stopwatch counter: BCD/binary agreement and flag consistency.
module stopwatch_counter_chk
    import stopwatch_pkg::*;
#(
    parameter int MAX_CNT = SW_MAX_CNT
) (
    input logic        CLK,
    input logic        reset,
    input logic [13:0] counter,
    input logic [15:0] bcd,
    input logic        at_max,
    input logic        at_min,
    input logic        bcd_overflow
);

    localparam logic [13:0] CNT_MAX = 14'(MAX_CNT);

    a_bcd_matches: assert property (@(posedge CLK) disable iff (reset)
        bcd_is_valid(bcd) && (bcd_to_bin(bcd) == counter));

    a_at_max: assert property (@(posedge CLK) disable iff (reset)
        at_max == (counter == CNT_MAX));

    a_at_min: assert property (@(posedge CLK) disable iff (reset)
        at_min == (counter == 14'd0));

    a_no_overflow: assert property (@(posedge CLK) disable iff (reset)
        !bcd_overflow);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch datapath: executes HOLD/INC/DEC/LOAD commands from the control FSM,
// keeping a saturating 0..MAX_CNT count in binary and in four chained BCD digits.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int MAX_CNT  = SW_MAX_CNT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [2:0]  cmd,
    input  logic [15:0] ext_bcd,
    output logic [13:0] counter,
    output logic [15:0] bcd,
    output logic        step,
    output logic        at_max,
    output logic        at_min
);

    localparam int              PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [13:0]     CNT_MAX  = 14'(MAX_CNT);
    localparam logic [15:0]     MAX_BCD  = {4'((MAX_CNT / 1000) % 10), 4'((MAX_CNT / 100) % 10),
                                            4'((MAX_CNT / 10) % 10),   4'(MAX_CNT % 10)};

    logic             is_inc_s;
    logic             is_dec_s;
    logic             is_load_s;
    logic [15:0]      ext_clamped_s;
    logic [15:0]      load_bcd_s;
    logic [13:0]      load_bin_s;
    logic             tick_s;
    logic             step_en_s;
    logic [4:0]       en_chain_s;
    logic [15:0]      bcd_s;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic [13:0]      counter_q;
    logic [13:0]      counter_d;
    logic             step_q;
    logic             at_max_q;
    logic             at_min_q;

    assign ext_clamped_s = clamp_bcd(ext_bcd);

    // Command decode; unused codes fall through as HOLD.
    always_comb begin
        is_inc_s   = 1'b0;
        is_dec_s   = 1'b0;
        is_load_s  = 1'b0;
        load_bcd_s = 16'h0000;
        load_bin_s = 14'd0;
        case (cmd)
            CMD_INC:       is_inc_s = 1'b1;
            CMD_DEC:       is_dec_s = 1'b1;
            CMD_LOAD_0:    is_load_s = 1'b1;
            CMD_LOAD_9999: begin
                is_load_s  = 1'b1;
                load_bcd_s = MAX_BCD;
                load_bin_s = CNT_MAX;
            end
            CMD_LOAD_EXT:  begin
                is_load_s  = 1'b1;
                load_bcd_s = ext_clamped_s;
                load_bin_s = bcd_to_bin(ext_clamped_s);
            end
            default:       is_load_s = 1'b0;
        endcase
    end

    assign tick_s    = (is_inc_s || is_dec_s) && (pre_q == PRE_LAST);
    assign step_en_s = tick_s && ((is_inc_s && (counter_q != CNT_MAX)) ||
                                  (is_dec_s && (counter_q != 14'd0)));

    // Prescaler and binary count next state; HOLD keeps the partial period.
    always_comb begin
        pre_d     = pre_q;
        counter_d = counter_q;
        if (is_load_s) begin
            pre_d     = {PRE_W{1'b0}};
            counter_d = load_bin_s;
        end else if (is_inc_s || is_dec_s) begin
            pre_d = tick_s ? {PRE_W{1'b0}} : pre_q + PRE_W'(1);
            if (step_en_s) begin
                counter_d = is_inc_s ? counter_q + 14'd1 : counter_q - 14'd1;
            end else begin
                counter_d = counter_q;
            end
        end else begin
            pre_d     = pre_q;
            counter_d = counter_q;
        end
    end

    // Datapath registers; flags derive from the next-state count so they track counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pre_q     <= {PRE_W{1'b0}};
            counter_q <= 14'd0;
            step_q    <= 1'b0;
            at_max_q  <= 1'b0;
            at_min_q  <= 1'b1;
        end else begin
            pre_q     <= pre_d;
            counter_q <= counter_d;
            step_q    <= step_en_s;
            at_max_q  <= (counter_d == CNT_MAX);
            at_min_q  <= (counter_d == 14'd0);
        end
    end

    assign en_chain_s[0] = step_en_s;

    for (genvar g = 0; g < 4; g++) begin : g_digit
        bcd_digit u_digit (
            .CLK        (CLK),
            .reset      (reset),
            .en_i       (en_chain_s[g]),
            .up_i       (is_inc_s),
            .load_i     (is_load_s),
            .load_val_i (load_bcd_s[4*g +: 4]),
            .digit_o    (bcd_s[4*g +: 4]),
            .cout_o     (en_chain_s[g+1])
        );
    end

    stopwatch_counter_chk #(
        .MAX_CNT (MAX_CNT)
    ) u_chk (
        .CLK          (CLK),
        .reset        (reset),
        .counter      (counter_q),
        .bcd          (bcd_s),
        .at_max       (at_max_q),
        .at_min       (at_min_q),
        .bcd_overflow (en_chain_s[4])
    );

    assign counter = counter_q;
    assign bcd     = bcd_s;
    assign step    = step_q;
    assign at_max  = at_max_q;
    assign at_min  = at_min_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter with TICK_DIV=4; expected values are hand-computed.
module tb_stopwatch_counter;
    import stopwatch_pkg::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic [2:0]  cmd;
    logic [15:0] ext_bcd;
    logic [13:0] counter;
    logic [15:0] bcd;
    logic        step;
    logic        at_max;
    logic        at_min;

    int n_checks = 0;
    int n_errs   = 0;
    int step_cnt = 0;

    always #5 CLK = ~CLK;

    stopwatch_counter #(
        .TICK_DIV (4)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .cmd     (cmd),
        .ext_bcd (ext_bcd),
        .counter (counter),
        .bcd     (bcd),
        .step    (step),
        .at_max  (at_max),
        .at_min  (at_min)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Apply a command for n cycles, sampling 1 time unit after each edge.
    task automatic run(input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            cmd = c;
            @(posedge CLK);
            #1;
            step_cnt += int'(step);
        end
    endtask

    initial begin
        reset   = 1'b1;
        cmd     = CMD_HOLD;
        ext_bcd = 16'h0000;
        run(CMD_HOLD, 2);
        check("rst_counter", 32'(counter), 32'd0);
        check("rst_bcd",     32'(bcd),     32'h0000);
        check("rst_step",    32'(step),    32'd0);
        check("rst_at_max",  32'(at_max),  32'd0);
        check("rst_at_min",  32'(at_min),  32'd1);
        reset = 1'b0;

        // 1: INC for 40 cycles -> one step every 4 cycles
        step_cnt = 0;
        run(CMD_INC, 3);
        check("t1_pre_tick_cnt", 32'(counter), 32'd0);
        check("t1_pre_tick_step", 32'(step), 32'd0);
        run(CMD_INC, 1);
        check("t1_first_cnt",  32'(counter), 32'd1);
        check("t1_first_step", 32'(step),    32'd1);
        check("t1_first_min",  32'(at_min),  32'd0);
        run(CMD_INC, 1);
        check("t1_step_pulse", 32'(step), 32'd0);
        run(CMD_INC, 35);
        check("t1_counter", 32'(counter), 32'd10);
        check("t1_bcd",     32'(bcd),     32'h0010);
        check("t1_steps",   32'(step_cnt), 32'd10);

        // 2: saturation at the top, then one DEC step
        run(CMD_LOAD_9999, 1);
        check("t2_load_cnt", 32'(counter), 32'd9999);
        check("t2_load_bcd", 32'(bcd),     32'h9999);
        check("t2_at_max",   32'(at_max),  32'd1);
        step_cnt = 0;
        run(CMD_INC, 12);
        check("t2_sat_cnt",   32'(counter),  32'd9999);
        check("t2_sat_steps", 32'(step_cnt), 32'd0);
        run(CMD_DEC, 4);
        check("t2_dec_cnt",  32'(counter), 32'd9998);
        check("t2_dec_bcd",  32'(bcd),     32'h9998);
        check("t2_dec_step", 32'(step),    32'd1);
        check("t2_dec_max",  32'(at_max),  32'd0);

        // 3: external preset with digit clamp, borrow ripple
        ext_bcd = 16'h1A09;
        run(CMD_LOAD_EXT, 1);
        check("t3_ext_cnt", 32'(counter), 32'd1909);
        check("t3_ext_bcd", 32'(bcd),     32'h1909);
        ext_bcd = 16'h5555;
        run(CMD_DEC, 4);
        check("t3_dec_cnt", 32'(counter), 32'd1908);
        check("t3_dec_bcd", 32'(bcd),     32'h1908);
        ext_bcd = 16'h0100;
        run(CMD_LOAD_EXT, 1);
        run(CMD_DEC, 4);
        check("t3_borrow_cnt", 32'(counter), 32'd99);
        check("t3_borrow_bcd", 32'(bcd),     32'h0099);
        ext_bcd = 16'hFFFF;
        run(CMD_LOAD_EXT, 1);
        check("t3_clamp_cnt", 32'(counter), 32'd9999);
        check("t3_clamp_max", 32'(at_max),  32'd1);
        ext_bcd = 16'h0099;
        run(CMD_LOAD_EXT, 3);
        check("t3_held_load", 32'(counter), 32'd99);

        // 4: pause keeps the partial prescaler period; INC->DEC keeps it too
        run(CMD_INC, 2);
        run(CMD_HOLD, 10);
        check("t4_hold_cnt", 32'(counter), 32'd99);
        run(CMD_INC, 1);
        check("t4_resume1_step", 32'(step), 32'd0);
        run(CMD_INC, 1);
        check("t4_resume2_step", 32'(step),    32'd1);
        check("t4_resume2_cnt",  32'(counter), 32'd100);
        check("t4_resume2_bcd",  32'(bcd),     32'h0100);
        run(CMD_INC, 2);
        run(CMD_DEC, 2);
        check("t4_dir_change_cnt",  32'(counter), 32'd99);
        check("t4_dir_change_step", 32'(step),    32'd1);

        // 5: underflow saturation and LOAD clearing the prescaler
        run(CMD_LOAD_0, 1);
        step_cnt = 0;
        run(CMD_DEC, 20);
        check("t5_sat_cnt",   32'(counter),  32'd0);
        check("t5_sat_min",   32'(at_min),   32'd1);
        check("t5_sat_steps", 32'(step_cnt), 32'd0);
        run(CMD_INC, 3);
        run(CMD_LOAD_0, 1);
        run(CMD_INC, 3);
        check("t5_pre_cleared", 32'(counter), 32'd0);
        run(CMD_INC, 1);
        check("t5_after_clear", 32'(counter), 32'd1);

        // 6: reset beats INC mid-count; codes 110/111 behave as HOLD
        ext_bcd = 16'h0057;
        run(CMD_LOAD_EXT, 1);
        run(CMD_INC, 2);
        check("t6_pre_rst_cnt", 32'(counter), 32'd57);
        reset = 1'b1;
        run(CMD_INC, 1);
        check("t6_rst_cnt",  32'(counter), 32'd0);
        check("t6_rst_bcd",  32'(bcd),     32'h0000);
        check("t6_rst_min",  32'(at_min),  32'd1);
        reset = 1'b0;
        run(CMD_INC, 3);
        check("t6_rst_pre", 32'(counter), 32'd0);
        run(CMD_INC, 1);
        check("t6_rst_first", 32'(counter), 32'd1);
        run(CMD_INC, 2);
        run(3'b111, 5);
        run(3'b110, 3);
        check("t6_illegal_hold", 32'(counter), 32'd1);
        run(CMD_INC, 1);
        check("t6_resume1", 32'(counter), 32'd1);
        run(CMD_INC, 1);
        check("t6_resume2", 32'(counter), 32'd2);
        check("t6_resume2_bcd", 32'(bcd), 32'h0002);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
